// File: rtl/tv_code_reader.sv
// rtl/tv_code_reader.sv - walks the TV code table ROM and emits carrier/on/off pulse descriptors
module tv_code_reader #(
  parameter int SIZE            = 1000,
  parameter int DATA_WIDTH      = 8,
  parameter int CODE_INDEX_BITS = 8,
  localparam int ADDRESS_BITS   = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [ADDRESS_BITS-1:0]    rom_address,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  input  logic                       rom_address_overflow,
  output logic                       pair_valid,
  input  logic                       pair_ready,
  output logic [7:0]                 pair_carrier,
  output logic [15:0]                pair_on,
  output logic [15:0]                pair_off,
  output logic                       pair_last,
  output logic [CODE_INDEX_BITS-1:0] code_index,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  // The table format is byte-oriented; any other ROM width is a build mistake.
  if (DATA_WIDTH != 8) begin : g_width_check
    $error("tv_code_reader: DATA_WIDTH must be 8");
  end

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_CARRIER,
    ST_RD_COUNT,
    ST_RD_ON_H,
    ST_RD_ON_L,
    ST_RD_OFF_H,
    ST_RD_OFF_L,
    ST_PRESENT,
    ST_FINISH,
    ST_ERROR
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] remaining;
  logic [7:0] carrier;
  logic [7:0] on_hi;
  logic [7:0] on_lo;
  logic [7:0] off_hi;
  logic [7:0] off_lo;
  logic       reading;
  logic       is_last;
  logic       transfer;

  assign reading  = (state inside {ST_RD_CARRIER, ST_RD_COUNT, ST_RD_ON_H,
                                   ST_RD_ON_L, ST_RD_OFF_H, ST_RD_OFF_L});
  assign is_last  = (remaining == 8'd1);
  assign transfer = (state == ST_PRESENT) && pair_ready && !abort;

  assign pair_carrier = carrier;
  assign pair_on      = {on_hi, on_lo};
  assign pair_off     = {off_hi, off_lo};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and outputs; abort pre-empts every non-idle state.
  always_comb begin
    state_next = state;
    pair_valid = 1'b0;
    pair_last  = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      ST_IDLE:       if (start) state_next = ST_RD_CARRIER;
      ST_RD_CARRIER: begin
        if (rom_address_overflow)  state_next = ST_ERROR;
        else if (rom_data == 8'h00) state_next = ST_FINISH;
        else                        state_next = ST_RD_COUNT;
      end
      ST_RD_COUNT: begin
        if (rom_address_overflow || rom_data == 8'h00) state_next = ST_ERROR;
        else                                           state_next = ST_RD_ON_H;
      end
      ST_RD_ON_H:  state_next = rom_address_overflow ? ST_ERROR : ST_RD_ON_L;
      ST_RD_ON_L:  state_next = rom_address_overflow ? ST_ERROR : ST_RD_OFF_H;
      ST_RD_OFF_H: state_next = rom_address_overflow ? ST_ERROR : ST_RD_OFF_L;
      ST_RD_OFF_L: state_next = rom_address_overflow ? ST_ERROR : ST_PRESENT;
      ST_PRESENT: begin
        pair_valid = 1'b1;
        pair_last  = is_last;
        if (pair_ready) state_next = is_last ? ST_RD_CARRIER : ST_RD_ON_H;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERROR: begin
        error      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Datapath: address walk, field latches, pair countdown and entry index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_address <= '0;
      code_index  <= '0;
      remaining   <= 8'd0;
      carrier     <= 8'd0;
      on_hi       <= 8'd0;
      on_lo       <= 8'd0;
      off_hi      <= 8'd0;
      off_lo      <= 8'd0;
    end else if (!abort) begin
      if (state == ST_IDLE && start) begin
        rom_address <= '0;
        code_index  <= '0;
      end
      if (reading && !rom_address_overflow) begin
        rom_address <= rom_address + ADDRESS_BITS'(1);
        case (state)
          ST_RD_CARRIER: if (rom_data != 8'h00) carrier <= rom_data;
          ST_RD_COUNT:   remaining <= rom_data;
          ST_RD_ON_H:    on_hi  <= rom_data;
          ST_RD_ON_L:    on_lo  <= rom_data;
          ST_RD_OFF_H:   off_hi <= rom_data;
          ST_RD_OFF_L:   off_lo <= rom_data;
          default: ;
        endcase
      end
      if (transfer) begin
        remaining <= remaining - 8'd1;
        if (is_last) code_index <= code_index + CODE_INDEX_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_tv_code_reader.sv
// tb/tb_tv_code_reader.sv - directed self-checking bench for tv_code_reader
module tb_tv_code_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  rom_address;
  logic [7:0]  rom_data;
  logic        rom_address_overflow;
  logic        pair_valid;
  logic        pair_ready = 1'b1;
  logic [7:0]  pair_carrier;
  logic [15:0] pair_on;
  logic [15:0] pair_off;
  logic        pair_last;
  logic [7:0]  code_index;
  logic        busy;
  logic        done;
  logic        error;

  logic [7:0]  rom_mem [64];
  int          rom_size = 64;
  int          checks = 0;
  int          failures = 0;

  tv_code_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_address(rom_address), .rom_data(rom_data),
    .rom_address_overflow(rom_address_overflow),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_carrier(pair_carrier), .pair_on(pair_on), .pair_off(pair_off),
    .pair_last(pair_last), .code_index(code_index),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Combinational ROM model with a configurable depth.
  always_comb begin
    rom_data             = (int'(rom_address) < 64) ? rom_mem[rom_address[5:0]] : 8'h00;
    rom_address_overflow = (int'(rom_address) >= rom_size);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] bytes [$], input int depth);
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < bytes.size(); i++) rom_mem[i] = bytes[i];
    rom_size = depth;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!pair_valid && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, pair_valid}, 32'd1);
  endtask

  task automatic chk_pair(input string tag, input logic [7:0] car, input logic [15:0] on,
                          input logic [15:0] off, input logic last, input logic [7:0] idx);
    chk({tag, "_valid"}, {31'd0, pair_valid}, 32'd1);
    chk({tag, "_car"}, {24'd0, pair_carrier}, {24'd0, car});
    chk({tag, "_on"}, {16'd0, pair_on}, {16'd0, on});
    chk({tag, "_off"}, {16'd0, pair_off}, {16'd0, off});
    chk({tag, "_last"}, {31'd0, pair_last}, {31'd0, last});
    chk({tag, "_idx"}, {24'd0, code_index}, {24'd0, idx});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] tbl1 [$];
  logic [7:0] tbl2 [$];
  logic [7:0] tbl3 [$];
  logic [7:0] tbl4 [$];
  int         seen_done;

  initial begin
    tbl1 = '{8'h1A, 8'h02, 8'h00, 8'h10, 8'h00, 8'h20, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00};
    tbl2 = '{8'h1A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h2B, 8'h01, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    tbl3 = '{8'h1A, 8'h02, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07};
    tbl4 = '{8'h1A, 8'h00};
    load(tbl1, 64);

    // Reset state
    #2;
    chk("rst_valid", {31'd0, pair_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {22'd0, rom_address}, 32'd0);
    chk("rst_done_err", {30'd0, done, error}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Test 1: two-pair entry, ready held high, exact first-pair latency
    kick();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 7; i++) begin
      chk("t1_early_valid", {31'd0, pair_valid}, 32'd0);
      step();
    end
    chk_pair("t1_p0", 8'h1A, 16'h0010, 16'h0020, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step();
    chk_pair("t1_p1", 8'h1A, 16'h0100, 16'h0200, 1'b1, 8'd0);
    step();
    chk("t1_no_done_yet", {31'd0, done}, 32'd0);
    step();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_done_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1_done_once", {31'd0, done}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Test 2: backpressure on the first pair
    pair_ready = 1'b0;
    kick();
    wait_valid("t2_wait0");
    for (int i = 0; i < 10; i++) begin
      chk_pair("t2_hold", 8'h1A, 16'h0010, 16'h0020, 1'b0, 8'd0);
      step();
    end
    pair_ready = 1'b1;
    step();
    chk("t2_released", {31'd0, pair_valid}, 32'd0);
    wait_valid("t2_wait1");
    chk_pair("t2_p1", 8'h1A, 16'h0100, 16'h0200, 1'b1, 8'd0);
    seen_done = 0;
    while (busy) begin
      if (done) seen_done++;
      if (seen_done > 5) break;
      step();
    end
    chk("t2_done_count", seen_done, 32'd1);

    // Test 3: two entries; a start issued mid-walk must be ignored
    load(tbl2, 64);
    kick();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t3_wait0");
    chk_pair("t3_p0", 8'h1A, 16'h0001, 16'h0002, 1'b1, 8'd0);
    step();
    wait_valid("t3_wait1");
    chk_pair("t3_p1", 8'h2B, 16'h0003, 16'h0004, 1'b1, 8'd1);
    wait_idle("t3_idle");

    // Test 4: 8-byte ROM without terminator overflows reading the second pair
    load(tbl3, 8);
    kick();
    wait_valid("t4_wait0");
    chk_pair("t4_p0", 8'h1A, 16'h0005, 16'h0006, 1'b0, 8'd0);
    step();
    step();
    step();
    chk("t4_ovf_addr", {22'd0, rom_address}, 32'd8);
    step();
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_no_done", {31'd0, done}, 32'd0);
    chk("t4_no_valid", {31'd0, pair_valid}, 32'd0);
    step();
    chk("t4_err_once", {31'd0, error}, 32'd0);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // Test 5: pair_count of zero
    load(tbl4, 64);
    kick();
    chk("t5_v_carrier", {31'd0, pair_valid}, 32'd0);
    step();
    chk("t5_v_count", {31'd0, pair_valid}, 32'd0);
    step();
    chk("t5_error", {31'd0, error}, 32'd1);
    chk("t5_no_valid", {31'd0, pair_valid}, 32'd0);
    step();
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // Test 6: abort in RD_ON_L, then start+abort together in IDLE
    load(tbl1, 64);
    kick();
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_abort_idle", {31'd0, busy}, 32'd0);
    chk("t6_abort_pulses", {30'd0, done, error}, 32'd0);
    step();
    chk("t6_abort_quiet", {30'd0, done, error}, 32'd0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_abort_wins", {31'd0, busy}, 32'd0);

    // Test 7: asynchronous reset while a pair is presented
    pair_ready = 1'b0;
    kick();
    wait_valid("t7_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", {31'd0, pair_valid}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_car", {24'd0, pair_carrier}, 32'd0);
    chk("t7_on", {16'd0, pair_on}, 32'd0);
    chk("t7_addr", {22'd0, rom_address}, 32'd0);
    chk("t7_pulses", {30'd0, done, error}, 32'd0);
    step();
    rst_n = 1'b1;
    pair_ready = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
